// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve / comparator_eq                                             |
// | RV32I branch resolution: compare, decide, redirect target, taken counter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_eq
);
  assign o_eq = (i_a == i_b);
endmodule

module branch_resolve #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  rs1,
  input  logic [N-1:0]  rs2,
  input  logic [2:0]    funct3,
  input  logic [N-1:0]  pc,
  input  logic [N-1:0]  imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          taken,
  output logic [N-1:0]  target,
  output logic          illegal,
  output logic [CW-1:0] taken_count
);
  localparam logic [2:0]    c_beq     = 3'b000;
  localparam logic [2:0]    c_bne     = 3'b001;
  localparam logic [2:0]    c_blt     = 3'b100;
  localparam logic [2:0]    c_bge     = 3'b101;
  localparam logic [2:0]    c_bltu    = 3'b110;
  localparam logic [2:0]    c_bgeu    = 3'b111;
  localparam logic [N-1:0]  c_four    = N'(4);
  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

  logic          w_eq;
  logic          w_borrow;
  logic          w_diff_msb;
  logic [N-2:0]  w_diff_unused;
  logic          w_ovf;
  logic          w_lt;
  logic          w_ltu;
  logic          w_taken;
  logic          w_illegal;
  logic [N-1:0]  w_target;
  logic          w_in_xfer;
  logic          w_out_xfer;

  logic          r_out_valid;
  logic          r_taken;
  logic [N-1:0]  r_target;
  logic          r_illegal;
  logic [CW-1:0] r_count;

  comparator_eq #(.N(N)) u_eq (
    .i_a  (rs1),
    .i_b  (rs2),
    .o_eq (w_eq)
  );

  // Zero-extended subtract: bit N is the unsigned borrow, bit N-1 the N-bit sign.
  assign {w_borrow, w_diff_msb, w_diff_unused} = {1'b0, rs1} - {1'b0, rs2};
  assign w_ltu = w_borrow;
  assign w_ovf = (rs1[N-1] ^ rs2[N-1]) & (rs1[N-1] ^ w_diff_msb);
  assign w_lt  = w_diff_msb ^ w_ovf;

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (funct3)
      c_beq:   w_taken = w_eq;
      c_bne:   w_taken = ~w_eq;
      c_blt:   w_taken = w_lt;
      c_bge:   w_taken = ~w_lt;
      c_bltu:  w_taken = w_ltu;
      c_bgeu:  w_taken = ~w_ltu;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_target   = w_taken ? (pc + imm) : (pc + c_four);

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_illegal   <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_taken     <= w_taken;
        r_target    <= w_target;
        r_illegal   <= w_illegal;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
      // Counts results as they leave the stage, not as they enter.
      if (w_out_xfer && r_taken && (r_count != c_cnt_max)) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign taken       = r_taken;
  assign target      = r_target;
  assign illegal     = r_illegal;
  assign taken_count = r_count;
endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_resolve                                                          |
// | Directed scoreboard bench for branch_resolve (N=32, CW=4).                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_resolve;
  localparam int N  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  rs1, rs2, pc, imm, target;
  logic [2:0]    funct3;
  logic          out_valid, out_ready, taken, illegal;
  logic [CW-1:0] taken_count;

  typedef struct packed {
    logic          tk;
    logic [N-1:0]  tgt;
    logic          ill;
  } res_t;

  res_t q[$];
  int   model_cnt = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  branch_resolve #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .pc(pc), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target(target), .illegal(illegal), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [2:0] f, input logic [N-1:0] p,
                                 input logic [N-1:0] o);
    res_t r;
    r.ill = 1'b0;
    case (f)
      3'b000:  r.tk = (a == b);
      3'b001:  r.tk = (a != b);
      3'b100:  r.tk = ($signed(a) < $signed(b));
      3'b101:  r.tk = !($signed(a) < $signed(b));
      3'b110:  r.tk = (a < b);
      3'b111:  r.tk = !(a < b);
      default: begin r.tk = 1'b0; r.ill = 1'b1; end
    endcase
    r.tgt = r.tk ? p + o : p + 32'd4;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] p, input logic [N-1:0] o);
    in_valid = v; funct3 = f; rs1 = a; rs2 = b; pc = p; imm = o;
  endtask

  // One clock: check outputs against the scoreboard head, then model the edge.
  task automatic cycle(input string tag);
    logic exp_ready;
    #1;
    exp_ready = (q.size() == 0) || out_ready;
    chk({tag, "/out_valid"}, out_valid, q.size() != 0);
    chk({tag, "/in_ready"}, in_ready, exp_ready);
    chk({tag, "/count"}, taken_count, model_cnt);
    if (q.size() != 0) begin
      chk({tag, "/taken"}, taken, q[0].tk);
      chk({tag, "/target"}, target, q[0].tgt);
      chk({tag, "/illegal"}, illegal, q[0].ill);
      if (out_ready) begin
        if (q[0].tk && model_cnt < 15) model_cnt++;
        void'(q.pop_front());
      end
    end
    if (in_valid && exp_ready) q.push_back(model(rs1, rs2, funct3, pc, imm));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    repeat (2) @(posedge clk);
    #1;
    chk("rst/out_valid", out_valid, 0);
    chk("rst/in_ready", in_ready, 1);
    chk("rst/count", taken_count, 0);
    chk("rst/taken", taken, 0);
    chk("rst/target", target, 0);
    chk("rst/illegal", illegal, 0);
    rst = 1'b1;

    // Compare decode: BLT taken, BLTU not, BEQ both ways
    cycle("blt");
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);          cycle("bltu");
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);          cycle("beq_ne");
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h100, 32'h20);  cycle("beq_eq");
    drive(1'b1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h200, 32'hFFFF_FFF0); cycle("bge");
    drive(1'b1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h200, 32'hFFFF_FFF0); cycle("bgeu");
    drive(1'b1, 3'b001, 32'h5, 32'h5, 32'h300, 32'h40);                  cycle("bne");
    drive(1'b1, 3'b010, 32'h1, 32'h1, 32'h400, 32'h40);                  cycle("ill010");
    drive(1'b1, 3'b011, 32'h1, 32'h2, 32'h500, 32'h40);                  cycle("ill011");
    drive(1'b1, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h40);            cycle("wrap");
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);                     cycle("drain0");
    chk("blt_target_const", model(32'hFFFF_FFFF, 32'h1, 3'b100, 32'h100, 32'h20).tgt, 32'h120);

    // Backpressure: A captured, then 3 stalled cycles offering B
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 32'h1, 32'h2, 32'h600, 32'h10);  cycle("bp_a");
    drive(1'b1, 3'b000, 32'h3, 32'h4, 32'h700, 32'h10);
    for (int i = 0; i < 3; i++) cycle("bp_stall");
    out_ready = 1'b1;
    cycle("bp_release");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i % 2 == 0 ? 3'b000 : 3'b110), 32'(i), 32'(2 * i), 32'h800 + 32'(16 * i), 32'h80);
      cycle("b2b");
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);  cycle("drain1");

    // Saturation: 20 taken transfers, then not-taken ones
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'b000, 32'(i), 32'(i), 32'h1000, 32'h8);
      cycle("sat");
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);  cycle("drain2");
    chk("count_sat", taken_count, 15);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b001, 32'(i), 32'(i), 32'h2000, 32'h8);
      cycle("sat_nt");
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);  cycle("drain3");
    chk("count_held", taken_count, 15);

    // Async reset while stalled, asserted between edges
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h9, 32'h9, 32'h3000, 32'h8);  cycle("stall_setup");
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("pre_areset/out_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset/out_valid", out_valid, 0);
    chk("areset/count", taken_count, 0);
    chk("areset/in_ready", in_ready, 1);
    q.delete();
    model_cnt = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);  cycle("post_rst");
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);             cycle("drain4");
    cycle("idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Pipelined branch-resolution stage; sits directly downstream of the operand read/forward logic and consumes rs1/rs2.
- Instantiates `comparator_eq` (N = N) for the equality term and derives the signed and unsigned less-than terms.
- Registers the branch decision (taken, next PC, illegal flag) behind a valid/ready handshake for the fetch redirect logic.
- Keeps a saturating count of taken branches for performance debug.

Parameters:
- N, 32, datapath width of rs1, rs2, pc, imm and target.
- CW, 16, width of the taken-branch counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a branch.
- in_ready  output  1  stage can accept a branch this cycle.
- rs1  input  N  first operand.
- rs2  input  N  second operand.
- funct3  input  3  RV32I branch funct3.
- pc  input  N  PC of the branch.
- imm  input  N  sign-extended branch offset.
- out_valid  output  1  registered result is valid.
- out_ready  input  1  downstream accepts the result.
- taken  output  1  branch taken.
- target  output  N  next PC.
- illegal  output  1  funct3 is 010 or 011.
- taken_count  output  CW  saturating count of taken branches delivered downstream.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, taken=0, target=0, illegal=0, taken_count=0. in_ready=1 follows combinationally from out_valid=0.
- Handshakes:
  - in_ready = ~out_valid | out_ready (combinational; full-throughput pipeline register).
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Latency: exactly 1 cycle. A branch accepted at edge k appears on the outputs after edge k, with out_valid=1.
- Compare terms, computed combinationally from rs1/rs2:
  - eq from `comparator_eq`.
  - lt: signed rs1 < rs2.
  - ltu: unsigned rs1 < rs2.
  - lt and ltu are taken from an (N+1)-bit subtraction plus sign/overflow correction; no `<` on signed types.
- Decision by funct3:
  - 000 BEQ: eq.
  - 001 BNE: ~eq.
  - 100 BLT: lt.
  - 101 BGE: ~lt.
  - 110 BLTU: ltu.
  - 111 BGEU: ~ltu.
  - 010/011: taken=0, illegal=1. All other codes give illegal=0.
- Target:
  - taken: pc + imm.
  - not taken (including illegal): pc + 4.
  - Both are N-bit modulo sums; wrap-around is silent.
- Register update:
  - Input transfer: out_valid<=1; taken, target, illegal load the new values.
  - Output transfer with no input transfer: out_valid<=0; data registers hold (don't-care).
  - Stall (out_valid & ~out_ready): all output registers hold; in_ready=0.
  - Simultaneous output and input transfer: new result replaces the old one in the same edge; no bubble.
- taken_count:
  - Increments by 1 on each output transfer with taken=1.
  - Saturates at 2^CW-1; never wraps.
  - Illegal and not-taken results do not count.
- Reset mid-operation: the pending result is discarded and taken_count clears immediately (asynchronous). The first edge after release behaves as from reset.
- No combinational path from in_valid or the data inputs to any output. The only combinational path is out_ready -> in_ready.

Test Plan:
- Reset and idle: hold rst=0 with in_valid=1 -> out_valid=0, taken_count=0, in_ready=1. Release rst; the next edge captures the branch.
- Compare decode, N=32, pc=0x100, imm=0x20, rs1=0xFFFFFFFF, rs2=0x1:
  - BLT -> taken=1, target=0x120.
  - BLTU -> taken=0, target=0x104.
  - BEQ -> taken=0; with rs2=0xFFFFFFFF, BEQ -> taken=1.
- Illegal and wrap: funct3=010 -> illegal=1, taken=0, target=pc+4. pc=0xFFFFFFFC, not taken -> target=0x0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no input lost. Then out_ready=1 with 5 back-to-back branches -> 5 results in 5 consecutive cycles, in order.
- Counter saturation, CW=4: 20 taken transfers -> taken_count=15 and held; not-taken transfers leave it unchanged.
- Async reset mid-stall: out_valid=1, out_ready=0, assert rst between edges -> out_valid and taken_count drop to 0 before the next clock edge.
